// File: rtl/simd_operand_feeder.sv
// Command-driven operand feeder: it buffers operand pairs in a small FIFO and issues bursts of them
// to a SIMD core. After each burst it inserts a fixed idle gap so the core pipeline can flush.
module simd_operand_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_instruction,
  input  logic [5:0]   cmd_data_size,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [127:0] op_a,
  input  logic [127:0] op_b,
  output logic         valid_instruction,
  output logic [2:0]   instruction,
  output logic [5:0]   data_size,
  output logic         valid_data,
  output logic [127:0] mc_data_in_opa,
  output logic [127:0] mc_data_in_opb,
  output logic         busy,
  output logic         burst_done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    issue_cnt_q, issue_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [127:0]  mem_a_q [FIFO_DEPTH];
  logic [127:0]  mem_b_q [FIFO_DEPTH];

  logic          cmd_ready_q, cmd_ready_d;
  logic          op_ready_q, op_ready_d;
  logic          valid_instruction_q, valid_instruction_d;
  logic [2:0]    instruction_q, instruction_d;
  logic [5:0]    data_size_q, data_size_d;
  logic          valid_data_q, valid_data_d;
  logic [127:0]  opa_q, opa_d, opb_q, opb_d;
  logic          busy_q, busy_d;
  logic          burst_done_q, burst_done_d;

  logic          push, pop;

  always_comb begin
    // Pop decisions use the pre-push occupancy, so a freshly written pair is never bypassed.
    push = op_valid && op_ready_q;
    pop  = (state_q == ISSUE) && (count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    instruction_d = instruction_q;
    data_size_d   = data_size_q;
    opa_d         = opa_q;
    opb_d         = opb_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d       = ISSUE;
          instruction_d = cmd_instruction;
          data_size_d   = cmd_data_size;
          issue_cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (pop) begin
          issue_cnt_d = issue_cnt_q + 7'd1;
          if (issue_cnt_q == {1'b0, data_size_q}) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      opa_d = mem_a_q[rd_ptr_q];
      opb_d = mem_b_q[rd_ptr_q];
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    cmd_ready_d         = (state_d == IDLE);
    op_ready_d          = (count_d != CW'(FIFO_DEPTH));
    valid_instruction_d = (state_d == ISSUE);
    valid_data_d        = pop;
    busy_d              = (state_d != IDLE);
    burst_done_d        = (state_d == GAP) && (gap_cnt_d == GW'(GAP_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= op_a;
      mem_b_q[wr_ptr_q] <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      issue_cnt_q         <= '0;
      gap_cnt_q           <= '0;
      cmd_ready_q         <= 1'b0;
      op_ready_q          <= 1'b0;
      valid_instruction_q <= 1'b0;
      instruction_q       <= '0;
      data_size_q         <= '0;
      valid_data_q        <= 1'b0;
      opa_q               <= '0;
      opb_q               <= '0;
      busy_q              <= 1'b0;
      burst_done_q        <= 1'b0;
    end else begin
      state_q             <= state_d;
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      count_q             <= count_d;
      issue_cnt_q         <= issue_cnt_d;
      gap_cnt_q           <= gap_cnt_d;
      cmd_ready_q         <= cmd_ready_d;
      op_ready_q          <= op_ready_d;
      valid_instruction_q <= valid_instruction_d;
      instruction_q       <= instruction_d;
      data_size_q         <= data_size_d;
      valid_data_q        <= valid_data_d;
      opa_q               <= opa_d;
      opb_q               <= opb_d;
      busy_q              <= busy_d;
      burst_done_q        <= burst_done_d;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign op_ready          = op_ready_q;
  assign valid_instruction = valid_instruction_q;
  assign instruction       = instruction_q;
  assign data_size         = data_size_q;
  assign valid_data        = valid_data_q;
  assign mc_data_in_opa    = opa_q;
  assign mc_data_in_opb    = opb_q;
  assign busy              = busy_q;
  assign burst_done        = burst_done_q;
endmodule

// File: tb/tb_simd_operand_feeder.sv
// Bench for simd_operand_feeder: table-driven bursts plus hand-written corner sequences.
// A scoreboard of accepted operand pairs is compared against every valid_data strobe.
module tb_simd_operand_feeder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAPC  = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_instruction = '0;
  logic [5:0]   cmd_data_size = '0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [127:0] op_a = '0;
  logic [127:0] op_b = '0;
  logic         valid_instruction;
  logic [2:0]   instruction;
  logic [5:0]   data_size;
  logic         valid_data;
  logic [127:0] mc_data_in_opa;
  logic [127:0] mc_data_in_opb;
  logic         busy;
  logic         burst_done;

  always #5 clk = ~clk;

  simd_operand_feeder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instruction(cmd_instruction), .cmd_data_size(cmd_data_size),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .valid_instruction(valid_instruction), .instruction(instruction), .data_size(data_size),
    .valid_data(valid_data), .mc_data_in_opa(mc_data_in_opa), .mc_data_in_opb(mc_data_in_opb),
    .busy(busy), .burst_done(burst_done)
  );

  typedef struct { logic [127:0] a; logic [127:0] b; } pair_t;
  typedef struct {
    logic [2:0] ins; logic [5:0] size; int period; bit prefetch; int kind;
    int exp_pulses; int exp_span;
  } vec_t;

  pair_t src_q[$];
  pair_t sb_q[$];
  int    period = 1;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0, vd_cnt = 0, vd_first = 0, vd_last = 0, vi_drops = 0, gap_obs = 0, bd_obs = 0;
  logic  vi_prev = 1'b0;
  logic  hold_en = 1'b0;
  logic [127:0] last_a = '0, last_b = '0;
  vec_t  vecs[4];

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    pair_t p;
    forever begin
      @(negedge clk);
      cyc++;
      if (valid_data === 1'b1) begin
        chk_i("sb_not_empty_at_strobe", (sb_q.size() != 0) ? 1 : 0, 1);
        if (sb_q.size() != 0) begin
          p = sb_q.pop_front();
          chk_w("opa_data", mc_data_in_opa, p.a);
          chk_w("opb_data", mc_data_in_opb, p.b);
        end
        if (vd_cnt == 0) vd_first = cyc;
        vd_last = cyc;
        vd_cnt++;
        last_a = mc_data_in_opa;
        last_b = mc_data_in_opb;
      end else if (hold_en) begin
        chk_w("opa_hold", mc_data_in_opa, last_a);
        chk_w("opb_hold", mc_data_in_opb, last_b);
      end else begin
        last_a = mc_data_in_opa;
        last_b = mc_data_in_opb;
      end
      if (vi_prev === 1'b1 && valid_instruction === 1'b0) vi_drops++;
      vi_prev = valid_instruction;
      if (busy === 1'b1 && valid_instruction === 1'b0) gap_obs++;
      if (burst_done === 1'b1) bd_obs++;
    end
  endtask

  // Presents the head of src_q; an offer seen with op_ready high is taken at the next rising edge.
  task automatic producer_loop();
    int wait_c = 0;
    forever begin
      @(negedge clk);
      if (src_q.size() != 0 && wait_c == 0) begin
        op_valid = 1'b1;
        op_a = src_q[0].a;
        op_b = src_q[0].b;
        if (op_ready === 1'b1) begin
          sb_q.push_back(src_q.pop_front());
          wait_c = period - 1;
        end
      end else begin
        op_valid = 1'b0;
        if (wait_c != 0) wait_c--;
      end
    end
  endtask

  task automatic load_pairs(input int n, input int kind);
    pair_t p;
    logic [31:0] top;
    for (int k = 0; k < n; k++) begin
      if (kind == 0) begin
        p.a = 128'h11111111_22222222_55555555_66666666 ^ 128'(k);
      end else if (kind == 1) begin
        top = (k == 0) ? 32'hffffffff : 32'(64 - k);
        p.a = {top, 32'hcafe0000 | 32'(k), 32'(k * 7), 32'h5a5a5a5a};
      end else begin
        p.a = {$urandom, $urandom, $urandom, $urandom};
      end
      p.b = ~p.a ^ {96'h0, 32'(k)};
      src_q.push_back(p);
    end
  endtask

  task automatic wait_sb(input int n);
    int t = 0;
    while (sb_q.size() < n && t < 50) begin @(negedge clk); t++; end
    chk_i("prefetch_accepted", sb_q.size(), n);
    @(negedge clk);
  endtask

  task automatic clear_stats();
    vd_cnt = 0; vi_drops = 0; gap_obs = 0; bd_obs = 0;
  endtask

  task automatic send_cmd(input logic [2:0] ins, input logic [5:0] sz);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_instruction = ins;
    cmd_data_size = sz;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk_w("cmd_ready_seen", 128'(cmd_ready), 128'(1'b1));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_w("vi_after_handshake", 128'(valid_instruction), 128'(1'b1));
    chk_w("instruction_latched", 128'(instruction), 128'(ins));
    chk_w("data_size_latched", 128'(data_size), 128'(sz));
    chk_w("busy_in_issue", 128'(busy), 128'(1'b1));
    chk_w("cmd_ready_in_issue", 128'(cmd_ready), 128'(1'b0));
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (burst_done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    chk_w("burst_done_seen", 128'(burst_done), 128'(1'b1));
    @(negedge clk);
    chk_w("burst_done_one_cycle", 128'(burst_done), 128'(1'b0));
    chk_w("cmd_ready_after_done", 128'(cmd_ready), 128'(1'b1));
    chk_w("busy_after_done", 128'(busy), 128'(1'b0));
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_w({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1'b0));
    chk_w({tag, "_op_ready"}, 128'(op_ready), 128'(1'b0));
    chk_w({tag, "_vi"}, 128'(valid_instruction), 128'(1'b0));
    chk_w({tag, "_vd"}, 128'(valid_data), 128'(1'b0));
    chk_w({tag, "_busy"}, 128'(busy), 128'(1'b0));
    chk_w({tag, "_done"}, 128'(burst_done), 128'(1'b0));
    chk_w({tag, "_instr"}, 128'(instruction), 128'(0));
    chk_w({tag, "_size"}, 128'(data_size), 128'(0));
    chk_w({tag, "_opa"}, mc_data_in_opa, 128'(0));
    chk_w({tag, "_opb"}, mc_data_in_opb, 128'(0));
  endtask

  initial begin
    int viol;
    vecs[0] = '{ins: 3'b000, size: 6'd3,  period: 1, prefetch: 1'b1, kind: 0, exp_pulses: 4,  exp_span: 4};
    vecs[1] = '{ins: 3'b101, size: 6'd2,  period: 3, prefetch: 1'b0, kind: 2, exp_pulses: 3,  exp_span: 7};
    vecs[2] = '{ins: 3'b111, size: 6'd63, period: 1, prefetch: 1'b0, kind: 1, exp_pulses: 64, exp_span: 64};
    vecs[3] = '{ins: 3'b010, size: 6'd0,  period: 1, prefetch: 1'b1, kind: 2, exp_pulses: 1,  exp_span: 1};

    fork
      monitor_loop();
      producer_loop();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_w("cmd_ready_after_release", 128'(cmd_ready), 128'(1'b1));
    chk_w("op_ready_after_release", 128'(op_ready), 128'(1'b1));
    hold_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      clear_stats();
      period = vecs[i].period;
      if (vecs[i].prefetch) begin
        load_pairs(int'(vecs[i].size) + 1, vecs[i].kind);
        wait_sb(int'(vecs[i].size) + 1);
      end
      send_cmd(vecs[i].ins, vecs[i].size);
      if (!vecs[i].prefetch) load_pairs(int'(vecs[i].size) + 1, vecs[i].kind);
      wait_done(400);
      chk_i($sformatf("v%0d_pulses", i), vd_cnt, vecs[i].exp_pulses);
      chk_i($sformatf("v%0d_span", i), vd_last - vd_first + 1, vecs[i].exp_span);
      chk_i($sformatf("v%0d_vi_drops", i), vi_drops, 1);
      chk_i($sformatf("v%0d_gap_cycles", i), gap_obs, GAPC);
      chk_i($sformatf("v%0d_done_pulses", i), bd_obs, 1);
      chk_i($sformatf("v%0d_sb_drained", i), sb_q.size(), 0);
    end

    // Full FIFO: fifth pair held until the first pop frees a slot
    clear_stats();
    period = 1;
    load_pairs(5, 2);
    wait_sb(4);
    chk_w("full_op_ready_low", 128'(op_ready), 128'(1'b0));
    @(negedge clk);
    chk_i("full_fifth_held", sb_q.size(), 4);
    send_cmd(3'b100, 6'd4);
    chk_w("full_op_ready_low_at_issue", 128'(op_ready), 128'(1'b0));
    @(negedge clk);
    chk_w("full_first_strobe", 128'(valid_data), 128'(1'b1));
    chk_w("full_op_ready_after_pop", 128'(op_ready), 128'(1'b1));
    wait_done(100);
    chk_i("full_pulses", vd_cnt, 5);
    chk_i("full_src_drained", src_q.size(), 0);

    // Back-to-back: second command waits out the GAP
    clear_stats();
    load_pairs(2, 2);
    wait_sb(2);
    send_cmd(3'b001, 6'd1);
    viol = 0;
    for (int t = 0; t < 50 && !(busy === 1'b1 && valid_instruction === 1'b0); t++) @(negedge clk);
    chk_w("b2b_in_gap", 128'(valid_instruction), 128'(1'b0));
    cmd_valid = 1'b1;
    cmd_instruction = 3'b110;
    cmd_data_size = 6'd0;
    for (int t = 0; t < 50 && burst_done !== 1'b1; t++) begin
      if (cmd_ready !== 1'b0 || instruction !== 3'b001) viol++;
      @(negedge clk);
    end
    chk_i("b2b_gap_violations", viol, 0);
    chk_w("b2b_ready_low_at_done", 128'(cmd_ready), 128'(1'b0));
    chk_w("b2b_instr_held_at_done", 128'(instruction), 128'(3'b001));
    @(negedge clk);
    chk_w("b2b_ready_after_done", 128'(cmd_ready), 128'(1'b1));
    chk_w("b2b_instr_before_hs", 128'(instruction), 128'(3'b001));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_w("b2b_instr_after_hs", 128'(instruction), 128'(3'b110));
    chk_w("b2b_vi_second", 128'(valid_instruction), 128'(1'b1));
    load_pairs(1, 2);
    wait_done(100);
    chk_i("b2b_pulses", vd_cnt, 3);
    chk_i("b2b_done_pulses", bd_obs, 2);

    // Mid-burst reset at the second issued pair
    clear_stats();
    load_pairs(4, 2);
    wait_sb(4);
    send_cmd(3'b011, 6'd5);
    @(negedge clk);
    chk_w("mr_first_strobe", 128'(valid_data), 128'(1'b1));
    @(negedge clk);
    chk_w("mr_second_strobe", 128'(valid_data), 128'(1'b1));
    hold_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk_w("mr_cmd_ready_release", 128'(cmd_ready), 128'(1'b1));
    chk_w("mr_op_ready_release", 128'(op_ready), 128'(1'b1));
    chk_i("mr_no_burst_done", bd_obs, 0);
    hold_en = 1'b1;
    clear_stats();
    send_cmd(3'b110, 6'd0);
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_data !== 1'b0) viol++;
    end
    chk_i("mr_fifo_flushed", viol, 0);
    load_pairs(1, 2);
    wait_done(100);
    chk_i("mr_pulses", vd_cnt, 1);
    chk_i("mr_done_pulses", bd_obs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/simd_operand_feeder.md
SIMD_OPERAND_FEEDER -- requirements
Module: simd_operand_feeder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning operand-pair buffer depth (power of two, at least 2).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 8, meaning idle cycles inserted after each burst to flush the SIMD pipeline (at least 1).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock; every register updates on its rising edge.
REQ-005 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port cmd_valid SHALL be: input, 1 bit, command request.
REQ-007 Port cmd_ready SHALL be: output, 1 bit, command accept.
REQ-008 Port cmd_instruction SHALL be: input, 3 bits, SIMD opcode.
REQ-009 Port cmd_data_size SHALL be: input, 6 bits, burst length minus 1, in operand pairs.
REQ-010 Port op_valid SHALL be: input, 1 bit, operand pair present.
REQ-011 Port op_ready SHALL be: output, 1 bit, operand pair accept.
REQ-012 Ports op_a and op_b SHALL be: inputs, 128 bits each, operands A and B.
REQ-013 Port valid_instruction SHALL be: output, 1 bit, to the SIMD core.
REQ-014 Port instruction SHALL be: output, 3 bits, latched opcode.
REQ-015 Port data_size SHALL be: output, 6 bits, latched size.
REQ-016 Port valid_data SHALL be: output, 1 bit, operand strobe to the SIMD core.
REQ-017 Ports mc_data_in_opa and mc_data_in_opb SHALL be: outputs, 128 bits each, issued operands.
REQ-018 Port busy SHALL be: output, 1 bit, high when the FSM is not in IDLE.
REQ-019 Port burst_done SHALL be: output, 1 bit, one-cycle pulse at the end of GAP.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The FSM SHALL have the states IDLE, ISSUE and GAP.
REQ-022 A command handshake SHALL occur on cmd_valid && cmd_ready.
REQ-023 cmd_ready SHALL equal 1 only in IDLE.
REQ-024 On a command handshake the block SHALL latch instruction and data_size, clear the issue counter, and go to ISSUE.
REQ-025 On the cycle after the command handshake, valid_instruction SHALL rise and stay 1 throughout ISSUE.
REQ-026 valid_instruction SHALL drop on the cycle GAP is entered.
REQ-027 The operand FIFO SHALL accept a pair on op_valid && op_ready in every state, including IDLE (prefetch).
REQ-028 op_ready SHALL equal !full, with no write-through when full, even if a pop occurs in the same cycle.
REQ-029 In ISSUE, if the FIFO is non-empty, the block SHALL pop the head and present it on mc_data_in_opa/opb with valid_data=1 on the next cycle.
REQ-030 In ISSUE, if the FIFO is empty, valid_data SHALL be 0 that cycle (bubble), with the counter unchanged.
REQ-031 A push into an empty FIFO SHALL be issuable no earlier than the following cycle (no bypass).
REQ-032 The 7-bit issue counter SHALL increment per pop.
REQ-033 After pop number data_size+1 (counter == data_size at pop), the FSM SHALL go to GAP; burst lengths SHALL be 1..64.
REQ-034 mc_data_in_opa/opb SHALL hold their last value when valid_data=0.
REQ-035 In GAP, the block SHALL hold valid_data=0 and valid_instruction=0 for GAP_CYCLES cycles.
REQ-036 On the last GAP cycle the block SHALL assert burst_done for 1 cycle and return to IDLE.
REQ-037 A new command SHALL be accepted no earlier than the cycle after burst_done.
REQ-038 Pairs left in the FIFO after a burst SHALL be retained for the next burst.
REQ-039 cmd_valid asserted outside IDLE SHALL be ignored (not lost: the upstream holds it until cmd_ready).
REQ-040 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be derived from an occupancy count (0..FIFO_DEPTH).

Reset
REQ-041 Reset SHALL be synchronous and active-high, with priority over all other inputs.
REQ-042 On reset, the FSM SHALL go to IDLE and the FIFO SHALL be flushed (occupancy 0) and the counters cleared.
REQ-043 On reset, these outputs SHALL be 0: valid_instruction, valid_data, busy, burst_done, instruction, data_size, mc_data_in_opa, mc_data_in_opb.
REQ-044 On reset, cmd_ready SHALL be 0 during the reset cycle and 1 the cycle after release.
REQ-045 On reset, op_ready SHALL be 0 during the reset cycle and 1 the cycle after release.
REQ-046 Reset asserted mid-burst or mid-GAP SHALL abort without a burst_done pulse.

Verification
REQ-047 Basic burst: cmd (instruction=3'b000, data_size=3) with 4 pairs prefetched (A=128'h11111111_22222222_55555555_66666666...) -> 4 consecutive valid_data cycles in order, then 8 GAP cycles, then burst_done=1 for 1 cycle.
REQ-048 Starvation: data_size=2, pairs supplied one every 3 cycles -> valid_data pattern 1,0,0,1,0,0,1 with valid_instruction held 1 throughout.
REQ-049 Full FIFO: 5 pairs pushed back-to-back in IDLE -> op_ready=0 after the 4th, the 5th held by upstream and accepted the cycle after the first pop.
REQ-050 Back-to-back commands: command 2 presented during GAP -> cmd_ready=0 until after burst_done, and instruction changes only after the handshake.
REQ-051 Maximum burst: data_size=63, 64 pairs -> exactly 64 valid_data pulses, counter terminates without wrapping, and A=128'hffffffff_... through A=128'h00000001_... arrive unaltered.
REQ-052 Mid-burst reset: reset asserted at the 2nd issued pair of data_size=5 -> all outputs 0 next cycle, FIFO empty, no burst_done, and a new command is accepted normally after release.
